dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Shares the single data RAM (dram) between two requesters: the multi-cycle CPU's control/datapath (port cpu_*) and a DMA/debug loader (port dma_*).
- Sits between the requesters and the dram instance and owns the dram's address, write_data, read_not_write and cs pins.
- Sequences each access with a fixed, parameterised memory latency, returns read data and a one-cycle completion ack, and arbitrates by round-robin or fixed CPU priority.

Parameters:
- DATA_BUS_WIDTH, 24, data word width.
- ADDRESS_BUS_WIDTH, 11, dram address width.
- MEM_LATENCY, 2, number of cycles mem_cs is held per access. Legal range 1..15; 0 is illegal.
- CPU_PRIORITY, 0. 0 = round-robin; 1 = CPU always wins ties.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_rnw  in  1  1 = read, 0 = write.
- cpu_addr  in  ADDRESS_BUS_WIDTH  CPU word address.
- cpu_wdata  in  DATA_BUS_WIDTH  CPU store data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_BUS_WIDTH  registered CPU read data.
- dma_req, dma_rnw, dma_addr, dma_wdata, dma_ack, dma_rdata  same as the cpu_* ports, for the DMA port.
- mem_address  out  ADDRESS_BUS_WIDTH  to dram address.
- mem_write_data  out  DATA_BUS_WIDTH  to dram write_data.
- mem_read_not_write  out  1  to dram read_not_write.
- mem_cs  out  1  to dram cs.
- mem_read_data  in  DATA_BUS_WIDTH  from dram read_data.
- busy  out  1  high in ACCESS and DONE.
- owner  out  1  0 = CPU, 1 = DMA; the current or most recent winner.

Behaviour:
- Reset (reset = 0) forces these values immediately and asynchronously:
  - state = IDLE, count = 0, last_grant = 1 (so CPU wins the first tie).
  - All acks 0, cpu_rdata = dma_rdata = 0.
  - mem_address = 0, mem_write_data = 0, mem_read_not_write = 1, mem_cs = 0.
  - busy = 0, owner = 0.
- All outputs are registered; no combinational path from requester inputs to mem_* outputs.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - If no request is present, stay in IDLE with mem_cs = 0.
  - If exactly one req is high, that port wins.
  - If both are high: with CPU_PRIORITY = 1 the CPU wins; otherwise the port not equal to last_grant wins.
  - On the winning edge, latch the winner's addr/wdata/rnw into mem_address/mem_write_data/mem_read_not_write. Set mem_cs = 1, owner = winner, count = MEM_LATENCY-1, and go to ACCESS.
- ACCESS:
  - mem_* outputs stay stable; mem_cs = 1.
  - If count != 0, decrement count.
  - If count == 0 and the access is a read, capture mem_read_data into the winner's rdata register on that edge. Clear mem_cs, set mem_read_not_write = 1, and go to DONE.
- DONE:
  - The winner's ack = 1 for exactly this cycle.
  - last_grant = owner; go to IDLE.
- Latency:
  - req sampled in IDLE at cycle 0.
  - mem_cs high in cycles 1..MEM_LATENCY.
  - ack in cycle MEM_LATENCY+1.
  - Back-to-back throughput is one access per MEM_LATENCY+2 cycles (IDLE always costs one cycle).
- Handshake rules:
  - A requester must hold req/rnw/addr/wdata until its ack, and drop req in the cycle after ack unless it wants another access.
  - If req is still high when IDLE is re-entered, it is treated as a new request.
- Request dropped mid-transaction: the transaction is ignored for cancellation purposes; it completes and ack still pulses.
- Read data:
  - A port's rdata changes only on that port's read completion.
  - Writes and the other port's accesses never alter it.
- Requests that arrive during ACCESS or DONE wait; they are not queued beyond their level-held req.
- Reset asserted mid-ACCESS: mem_cs drops immediately, no ack is issued, and the in-flight access is discarded.
- Address and data are unsigned and passed through unmodified; there is no address checking or wrap logic.

Test Plan:
- Reset: hold reset = 0 with both reqs high -> all outputs at their reset values (mem_read_not_write = 1, all others 0); no mem_cs after release until the next IDLE sample.
- CPU read, MEM_LATENCY = 2, dram[0x005] = 0x00ABCD: cpu_req = 1, rnw = 1, addr = 0x005 -> mem_cs high cycles 1-2, mem_address = 0x005, cpu_ack pulse cycle 3, cpu_rdata = 0x00ABCD, dma_rdata unchanged at 0.
- DMA write then CPU read: dma writes 0x123456 to 0x7FF -> mem_read_not_write = 0 and mem_write_data = 0x123456 during ACCESS, dma_ack one cycle; CPU read of 0x7FF then returns cpu_rdata = 0x123456.
- Contention: both reqs held high continuously, CPU_PRIORITY = 0, MEM_LATENCY = 2 -> grants CPU, DMA, CPU, DMA with an ack every 4 cycles. With CPU_PRIORITY = 1 -> only cpu_ack pulses while cpu_req is held.
- Reset mid-access: assert reset in cycle 1 of ACCESS -> mem_cs = 0 immediately, no ack. After release, a fresh dma read of 0x010 completes normally with dma_ack in cycle MEM_LATENCY+1.
- Dropped req: cpu_req deasserted in cycle 1 of ACCESS -> cpu_ack still pulses in cycle 3; next IDLE with no req stays idle (busy = 0).

Source files
------------

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one data RAM between the CPU and DMA ports with fixed-latency
// sequenced accesses, a one-cycle ack per access, and round-robin or CPU-priority arbitration.
module dram_arbiter #(
    parameter int DATA_BUS_WIDTH    = 24,
    parameter int ADDRESS_BUS_WIDTH = 11,
    parameter int MEM_LATENCY       = 2,
    parameter int CPU_PRIORITY      = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cpu_req,
    input  logic                         cpu_rnw,
    input  logic [ADDRESS_BUS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    cpu_wdata,
    output logic                         cpu_ack,
    output logic [DATA_BUS_WIDTH-1:0]    cpu_rdata,
    input  logic                         dma_req,
    input  logic                         dma_rnw,
    input  logic [ADDRESS_BUS_WIDTH-1:0] dma_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    dma_wdata,
    output logic                         dma_ack,
    output logic [DATA_BUS_WIDTH-1:0]    dma_rdata,
    output logic [ADDRESS_BUS_WIDTH-1:0] mem_address,
    output logic [DATA_BUS_WIDTH-1:0]    mem_write_data,
    output logic                         mem_read_not_write,
    output logic                         mem_cs,
    input  logic [DATA_BUS_WIDTH-1:0]    mem_read_data,
    output logic                         busy,
    output logic                         owner
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                         state_q, state_d;
    logic [3:0]                     count_q, count_d;
    logic                           last_grant_q, last_grant_d;
    logic                           owner_q, owner_d;
    logic                           busy_q, busy_d;
    logic [ADDRESS_BUS_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_BUS_WIDTH-1:0]      wdata_q, wdata_d;
    logic                           rnw_q, rnw_d;
    logic                           cs_q, cs_d;
    logic                           cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
    logic [DATA_BUS_WIDTH-1:0]      cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
    logic                           grant, grant_dma, finish;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            busy_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rnw_q        <= 1'b1;
            cs_q         <= 1'b0;
            cpu_ack_q    <= 1'b0;
            dma_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            busy_q       <= busy_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rnw_q        <= rnw_d;
            cs_q         <= cs_d;
            cpu_ack_q    <= cpu_ack_d;
            dma_ack_q    <= dma_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    always_comb begin
        state_d = (state_q == IDLE)   ? ((cpu_req | dma_req) ? ACCESS : IDLE) :
                  (state_q == ACCESS) ? ((count_q == '0) ? DONE : ACCESS) : IDLE;
    end

    always_comb begin
        grant        = (state_q == IDLE) && (cpu_req || dma_req);
        // On a tie the DMA wins only in round-robin mode when the CPU had the last grant
        grant_dma    = dma_req && (!cpu_req || (CPU_PRIORITY == 0 && !last_grant_q));
        finish       = (state_q == ACCESS) && (count_q == '0);
        count_d      = grant ? 4'(MEM_LATENCY - 1) :
                       (state_q == ACCESS && count_q != '0) ? count_q - 4'd1 : count_q;
        owner_d      = grant ? grant_dma : owner_q;
        addr_d       = grant ? (grant_dma ? dma_addr : cpu_addr) : addr_q;
        wdata_d      = grant ? (grant_dma ? dma_wdata : cpu_wdata) : wdata_q;
        rnw_d        = grant ? (grant_dma ? dma_rnw : cpu_rnw) : (finish ? 1'b1 : rnw_q);
        cs_d         = grant || (state_q == ACCESS && count_q != '0);
        busy_d       = state_d != IDLE;
        cpu_ack_d    = finish && !owner_q;
        dma_ack_d    = finish && owner_q;
        cpu_rdata_d  = (finish && rnw_q && !owner_q) ? mem_read_data : cpu_rdata_q;
        dma_rdata_d  = (finish && rnw_q && owner_q) ? mem_read_data : dma_rdata_q;
        last_grant_d = (state_q == DONE) ? owner_q : last_grant_q;
    end

    assign mem_address        = addr_q;
    assign mem_write_data     = wdata_q;
    assign mem_read_not_write = rnw_q;
    assign mem_cs             = cs_q;
    assign cpu_ack            = cpu_ack_q;
    assign dma_ack            = dma_ack_q;
    assign cpu_rdata          = cpu_rdata_q;
    assign dma_rdata          = dma_rdata_q;
    assign busy               = busy_q;
    assign owner              = owner_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: drives a round-robin (latency 2) and a CPU-priority (latency 3) arbiter
// with shared stimulus and compares both against a transaction-timeline reference model.
module tb_dram_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_rnw, dma_req, dma_rnw;
    logic [10:0] cpu_addr, dma_addr;
    logic [23:0] cpu_wdata, dma_wdata;

    logic        cpu_ack [2], dma_ack [2], mem_rnw [2], mem_cs [2], busy [2], owner [2];
    logic [23:0] cpu_rdata [2], dma_rdata [2], mem_wd [2], mem_rd [2];
    logic [10:0] mem_addr [2];

    logic [23:0] dram [2][2048];
    logic [23:0] mm [2][2048];

    // Model: k = cycles since the grant edge (0 = idle), w = winner (1 = DMA)
    int          k [2];
    logic        w_m [2], last_m [2], rnw_m [2];
    logic [10:0] a_m [2];
    logic [23:0] d_m [2], cr_m [2], dr_m [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : gd
        dram_arbiter #(
            .DATA_BUS_WIDTH(24), .ADDRESS_BUS_WIDTH(11),
            .MEM_LATENCY(g == 0 ? 2 : 3), .CPU_PRIORITY(g)
        ) u_dut (
            .clock(clock), .reset(reset),
            .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
            .cpu_ack(cpu_ack[g]), .cpu_rdata(cpu_rdata[g]),
            .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
            .dma_ack(dma_ack[g]), .dma_rdata(dma_rdata[g]),
            .mem_address(mem_addr[g]), .mem_write_data(mem_wd[g]),
            .mem_read_not_write(mem_rnw[g]), .mem_cs(mem_cs[g]),
            .mem_read_data(mem_rd[g]), .busy(busy[g]), .owner(owner[g])
        );
        assign mem_rd[g] = dram[g][mem_addr[g]];
    end

    function automatic int lat(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            k[i] = 0; w_m[i] = 1'b0; last_m[i] = 1'b1; rnw_m[i] = 1'b1;
            a_m[i] = '0; d_m[i] = '0; cr_m[i] = '0; dr_m[i] = '0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (k[i] == 0) begin
                if (cpu_req || dma_req) begin
                    w_m[i]   = (cpu_req && dma_req) ? ((i == 1) ? 1'b0 : !last_m[i]) : dma_req;
                    rnw_m[i] = w_m[i] ? dma_rnw : cpu_rnw;
                    a_m[i]   = w_m[i] ? dma_addr : cpu_addr;
                    d_m[i]   = w_m[i] ? dma_wdata : cpu_wdata;
                    k[i]     = 1;
                end
            end else if (k[i] == lat(i)) begin
                if (!rnw_m[i]) mm[i][a_m[i]] = d_m[i];
                else if (w_m[i]) dr_m[i] = mm[i][a_m[i]];
                else cr_m[i] = mm[i][a_m[i]];
                k[i] = k[i] + 1;
            end else if (k[i] == lat(i) + 1) begin
                last_m[i] = w_m[i];
                k[i] = 0;
            end else begin
                k[i] = k[i] + 1;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            logic cs_e, done_e;
            cs_e   = (k[i] >= 1) && (k[i] <= lat(i));
            done_e = (k[i] == lat(i) + 1);
            chk($sformatf("%0d.mem_cs", i), 32'(mem_cs[i]), 32'(cs_e));
            chk($sformatf("%0d.busy", i), 32'(busy[i]), 32'(k[i] != 0));
            chk($sformatf("%0d.cpu_ack", i), 32'(cpu_ack[i]), 32'(done_e && !w_m[i]));
            chk($sformatf("%0d.dma_ack", i), 32'(dma_ack[i]), 32'(done_e && w_m[i]));
            chk($sformatf("%0d.owner", i), 32'(owner[i]), 32'(w_m[i]));
            chk($sformatf("%0d.mem_address", i), 32'(mem_addr[i]), 32'(a_m[i]));
            chk($sformatf("%0d.mem_write_data", i), 32'(mem_wd[i]), 32'(d_m[i]));
            chk($sformatf("%0d.mem_rnw", i), 32'(mem_rnw[i]), 32'(cs_e ? rnw_m[i] : 1'b1));
            chk($sformatf("%0d.cpu_rdata", i), 32'(cpu_rdata[i]), 32'(cr_m[i]));
            chk($sformatf("%0d.dma_rdata", i), 32'(dma_rdata[i]), 32'(dr_m[i]));
        end
    endtask

    // One clock: model decides on the inputs held since the last falling edge
    task automatic tick();
        logic        we [2];
        logic [10:0] wa [2];
        logic [23:0] wd [2];
        for (int i = 0; i < 2; i++) begin
            we[i] = mem_cs[i] && !mem_rnw[i];
            wa[i] = mem_addr[i];
            wd[i] = mem_wd[i];
        end
        model_step();
        @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < 2; i++)
            if (we[i]) dram[i][wa[i]] = wd[i];
        check_all();
    endtask

    task automatic single(input logic dma, input logic rnw, input logic [10:0] a, input logic [23:0] d);
        cpu_req = !dma; dma_req = dma;
        if (dma) begin dma_rnw = rnw; dma_addr = a; dma_wdata = d; end
        else begin cpu_rnw = rnw; cpu_addr = a; cpu_wdata = d; end
        tick();
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        int na_cpu [2], na_dma [2];
        #100_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int na_cpu [2], na_dma [2];
        reset = 1'b0;
        cpu_req = 1'b1; dma_req = 1'b1; cpu_rnw = 1'b1; dma_rnw = 1'b0;
        cpu_addr = 11'h005; dma_addr = 11'h7FF; cpu_wdata = 24'h111111; dma_wdata = 24'h222222;
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 2048; a++) begin
                dram[i][a] = 24'($urandom);
                mm[i][a]   = dram[i][a];
            end
        for (int i = 0; i < 2; i++) begin
            dram[i][5] = 24'h00ABCD;
            mm[i][5]   = 24'h00ABCD;
        end
        model_reset();
        repeat (3) begin
            @(negedge clock);
            check_all();
        end
        reset = 1'b1;
        cpu_req = 1'b0; dma_req = 1'b0;
        tick();

        single(1'b0, 1'b1, 11'h005, 24'h0);
        chk("cpu_read_5", 32'(cpu_rdata[0]), 32'h00ABCD);
        chk("dma_rdata_untouched", 32'(dma_rdata[0]), 32'h0);

        single(1'b1, 1'b0, 11'h7FF, 24'h123456);
        single(1'b0, 1'b1, 11'h7FF, 24'h0);
        chk("cpu_read_7ff", 32'(cpu_rdata[0]), 32'h123456);
        chk("cpu_read_7ff_prio", 32'(cpu_rdata[1]), 32'h123456);

        cpu_req = 1'b1; dma_req = 1'b1; cpu_rnw = 1'b1; dma_rnw = 1'b1;
        cpu_addr = 11'h005; dma_addr = 11'h7FF;
        na_cpu = '{0, 0}; na_dma = '{0, 0};
        repeat (16) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                na_cpu[i] += int'(cpu_ack[i]);
                na_dma[i] += int'(dma_ack[i]);
            end
        end
        chk("rr_cpu_acks", 32'(na_cpu[0]), 32'd2);
        chk("rr_dma_acks", 32'(na_dma[0]), 32'd2);
        chk("prio_cpu_acks", 32'(na_cpu[1]), 32'd3);
        chk("prio_dma_acks", 32'(na_dma[1]), 32'd0);
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (6) tick();

        dma_req = 1'b1; dma_rnw = 1'b1; dma_addr = 11'h010;
        tick();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%0d.rst_cs", i), 32'(mem_cs[i]), 32'd0);
            chk($sformatf("%0d.rst_ack", i), 32'(dma_ack[i]), 32'd0);
        end
        model_reset();
        @(negedge clock);
        check_all();
        reset = 1'b1;
        single(1'b1, 1'b1, 11'h010, 24'h0);
        chk("dma_read_after_rst", 32'(dma_rdata[0]), 32'(mm[0][16]));

        repeat (2000) begin
            cpu_req   = ($urandom_range(0, 3) != 0);
            dma_req   = ($urandom_range(0, 2) != 0);
            cpu_rnw   = 1'($urandom);
            dma_rnw   = 1'($urandom);
            cpu_addr  = 11'($urandom_range(0, 15));
            dma_addr  = 11'($urandom_range(0, 15));
            cpu_wdata = 24'($urandom);
            dma_wdata = 24'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
